// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage controller: runs the data-memory access over a
// variable-latency req/ack bus, stalls upstream while the access is in
// flight, resolves the branch and holds the MEM/WB register.
module mem_stage_ctrl #(
    parameter int unsigned size    = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [size-1:0] alu_resultado_MEM,
    input  logic [size-1:0] sum_resultado_MEM,
    input  logic [size-1:0] read_data2_MEM,
    input  logic [4:0]      wrin_MEM,
    input  logic            Branch_MEM,
    input  logic            MemRead_MEM,
    input  logic            MemtoReg_MEM,
    input  logic            MemWrite_MEM,
    input  logic            RegWrite_MEM,
    input  logic            ZERO_MEM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [size-1:0] dmem_addr,
    output logic [size-1:0] dmem_wdata,
    input  logic [size-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            stall_MEM,
    output logic            PCSrc,
    output logic [size-1:0] branch_target,
    output logic [size-1:0] read_data_WB,
    output logic [size-1:0] alu_resultado_WB,
    output logic [4:0]      wrin_WB,
    output logic            RegWrite_WB,
    output logic            MemtoReg_WB,
    output logic            bus_error,
    output logic            misaligned
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [size-1:0]   addr_q, addr_d;
    logic [size-1:0]   wdata_q, wdata_d;
    logic [size-1:0]   rd_wb_q, rd_wb_d;
    logic [size-1:0]   alu_wb_q, alu_wb_d;
    logic [4:0]        wrin_wb_q, wrin_wb_d;
    logic              regw_wb_q, regw_wb_d;
    logic              m2r_wb_q, m2r_wb_d;
    logic              buserr_q, buserr_d;
    logic              mis_q, mis_d;

    logic access;
    logic aligned;

    assign access  = MemRead_MEM | MemWrite_MEM;
    assign aligned = (alu_resultado_MEM[1:0] == 2'b00);

    assign PCSrc         = Branch_MEM & ZERO_MEM;
    assign branch_target = sum_resultado_MEM;

    assign dmem_req         = req_q;
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_wdata       = wdata_q;
    assign read_data_WB     = rd_wb_q;
    assign alu_resultado_WB = alu_wb_q;
    assign wrin_WB          = wrin_wb_q;
    assign RegWrite_WB      = regw_wb_q;
    assign MemtoReg_WB      = m2r_wb_q;
    assign bus_error        = buserr_q;
    assign misaligned       = mis_q;

    // Next-state, bus request, WB capture and stall decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_wb_d   = rd_wb_q;
        alu_wb_d  = alu_wb_q;
        wrin_wb_d = wrin_wb_q;
        regw_wb_d = regw_wb_q;
        m2r_wb_d  = m2r_wb_q;
        buserr_d  = buserr_q;
        mis_d     = mis_q;
        stall_MEM = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    regw_wb_d = 1'b0;
                    m2r_wb_d  = 1'b0;
                    if (aligned) begin
                        stall_MEM = 1'b1;
                        req_d     = 1'b1;
                        we_d      = MemWrite_MEM;
                        addr_d    = {alu_resultado_MEM[size-1:2], 2'b00};
                        wdata_d   = read_data2_MEM;
                        cnt_d     = '0;
                        state_d   = BUSY;
                    end else begin
                        mis_d = 1'b1;
                    end
                end else begin
                    alu_wb_d  = alu_resultado_MEM;
                    wrin_wb_d = wrin_MEM;
                    regw_wb_d = RegWrite_MEM;
                    m2r_wb_d  = MemtoReg_MEM;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        rd_wb_d = dmem_rdata;
                    end
                    alu_wb_d  = alu_resultado_MEM;
                    wrin_wb_d = wrin_MEM;
                    regw_wb_d = RegWrite_MEM;
                    m2r_wb_d  = MemtoReg_MEM;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    buserr_d  = 1'b1;
                    regw_wb_d = 1'b0;
                    m2r_wb_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    stall_MEM = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    regw_wb_d = 1'b0;
                    m2r_wb_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, bus and MEM/WB registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_wb_q   <= '0;
            alu_wb_q  <= '0;
            wrin_wb_q <= '0;
            regw_wb_q <= 1'b0;
            m2r_wb_q  <= 1'b0;
            buserr_q  <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_wb_q   <= rd_wb_d;
            alu_wb_q  <= alu_wb_d;
            wrin_wb_q <= wrin_wb_d;
            regw_wb_q <= regw_wb_d;
            m2r_wb_q  <= m2r_wb_d;
            buserr_q  <= buserr_d;
            mis_q     <= mis_d;
        end
    end

endmodule
